// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seg_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic [1:0] {
      GAP,
      DRIVE,
      COMMIT
   } seg_state_e;

   typedef struct packed {
      logic [3:0] val;
      logic       on;
      logic       dp;
   } digit_cfg_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seg_digit_buf.sv
// Per-digit shadow/active register file: writes land in the shadow copy,
// and the whole shadow is copied to the active copy on a commit strobe.
module seg_digit_buf
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int IDX_W      = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  digit_cfg_t       wr_cfg,
   input  logic             commit,
   input  logic [IDX_W-1:0] rd_idx,
   output digit_cfg_t       rd_cfg
);

   digit_cfg_t shadow_q [NUM_DIGITS];
   digit_cfg_t shadow_d [NUM_DIGITS];
   digit_cfg_t active_q [NUM_DIGITS];
   digit_cfg_t active_d [NUM_DIGITS];

   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      // Out-of-range indices complete the handshake but are discarded here.
      if (wr_en && (32'(wr_idx) < 32'(NUM_DIGITS))) begin
         shadow_d[wr_idx] = wr_cfg;
      end
      if (commit) begin
         active_d = shadow_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '{default: '0};
         active_q <= '{default: '0};
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign rd_cfg = active_q[rd_idx];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scans NUM_DIGITS common-anode digits through one shared hex decoder,
// with a blanking gap between digits and frame-aligned buffer commits.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter  int NUM_DIGITS = 8,
   parameter  int SCAN_DIV   = 1000,
   parameter  int GAP_CYCLES = 4,
   localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [3:0]            wr_val,
   input  logic                  wr_on,
   input  logic                  wr_dp,
   output logic [3:0]            dec_b,
   input  logic [7:0]            dec_h,
   output logic [7:0]            seg_n,
   output logic [NUM_DIGITS-1:0] dig_n,
   output logic                  frame_tick
);

   localparam int                CNT_W     = $clog2(max2(SCAN_DIV, GAP_CYCLES));
   localparam logic [CNT_W-1:0]  SCAN_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0]  PTR_LAST  = IDX_W'(NUM_DIGITS - 1);

   seg_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [7:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] dig_q, dig_d;
   logic                  tick;
   logic                  commit;
   digit_cfg_t            rd_cfg;
   digit_cfg_t            wr_cfg;
   logic                  dec_dp_unused;

   assign dec_dp_unused = dec_h[0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      ptr_d   = ptr_q;
      tick    = 1'b0;
      commit  = 1'b0;
      unique case (state_q)
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = DRIVE;
               cnt_d   = '0;
            end
         end
         DRIVE: begin
            if (cnt_q == SCAN_LAST) begin
               cnt_d = '0;
               if (ptr_q == PTR_LAST) begin
                  ptr_d   = '0;
                  tick    = 1'b1;
                  state_d = COMMIT;
               end else begin
                  ptr_d   = ptr_q + 1'b1;
                  state_d = GAP;
               end
            end
         end
         COMMIT: begin
            commit  = 1'b1;
            state_d = GAP;
            cnt_d   = '0;
         end
         default: begin
            state_d = GAP;
            cnt_d   = '0;
         end
      endcase
   end

   // Decoder bit0 carries no useful dp, so the controller's own dp replaces it.
   always_comb begin
      seg_d = SEG_BLANK;
      dig_d = '1;
      if (state_q == DRIVE) begin
         dig_d[ptr_q] = 1'b0;
         if (rd_cfg.on) begin
            seg_d = {dec_h[7:1], ~rd_cfg.dp};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= GAP;
         cnt_q   <= '0;
         ptr_q   <= '0;
         seg_q   <= SEG_BLANK;
         dig_q   <= '1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         seg_q   <= seg_d;
         dig_q   <= dig_d;
      end
   end

   assign wr_ready   = ~rst && (state_q != COMMIT);
   assign frame_tick = ~rst && tick;
   assign wr_cfg     = '{val: wr_val, on: wr_on, dp: wr_dp};

   seg_digit_buf #(
      .NUM_DIGITS(NUM_DIGITS),
      .IDX_W     (IDX_W)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .wr_en (wr_valid & wr_ready),
      .wr_idx(wr_idx),
      .wr_cfg(wr_cfg),
      .commit(commit),
      .rd_idx(ptr_q),
      .rd_cfg(rd_cfg)
   );

   assign dec_b = rd_cfg.val;
   assign seg_n = seg_q;
   assign dig_n = dig_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position model plus directed scenarios.
module tb_seg_scan_ctrl;

   localparam int N    = 4;
   localparam int S    = 8;
   localparam int G    = 2;
   localparam int SLOT = S + G;
   localparam int P    = N * SLOT + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [1:0] wr_idx = '0;
   logic [3:0] wr_val = '0;
   logic       wr_on = 1'b0;
   logic       wr_dp = 1'b0;
   logic [3:0] dec_b;
   logic [7:0] dec_h;
   logic [7:0] seg_n;
   logic [3:0] dig_n;
   logic       frame_tick;

   logic       rst5 = 1'b1;
   logic       wv5 = 1'b0;
   logic       wr5;
   logic [2:0] idx5 = '0;
   logic [3:0] val5 = '0;
   logic       on5 = 1'b0;
   logic       dp5 = 1'b0;
   logic [3:0] decb5;
   logic [7:0] dech5;
   logic [7:0] seg5;
   logic [4:0] dig5;
   logic       tick5;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Hex decoder: active-low segments a..g in bits 7..1; bit0 deliberately driven 0.
   function automatic logic [7:0] ex7(input logic [3:0] v);
      logic [6:0] pat;
      case (v)
         4'h0: pat = 7'h7E; 4'h1: pat = 7'h30; 4'h2: pat = 7'h6D; 4'h3: pat = 7'h79;
         4'h4: pat = 7'h33; 4'h5: pat = 7'h5B; 4'h6: pat = 7'h5F; 4'h7: pat = 7'h70;
         4'h8: pat = 7'h7F; 4'h9: pat = 7'h7B; 4'hA: pat = 7'h77; 4'hB: pat = 7'h1F;
         4'hC: pat = 7'h4E; 4'hD: pat = 7'h3D; 4'hE: pat = 7'h4F; default: pat = 7'h47;
      endcase
      return {~pat, 1'b0};
   endfunction

   assign dec_h = ex7(dec_b);
   assign dech5 = ex7(decb5);

   seg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(S), .GAP_CYCLES(G)) u_dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_idx(wr_idx), .wr_val(wr_val), .wr_on(wr_on), .wr_dp(wr_dp),
      .dec_b(dec_b), .dec_h(dec_h), .seg_n(seg_n), .dig_n(dig_n),
      .frame_tick(frame_tick)
   );

   seg_scan_ctrl #(.NUM_DIGITS(5), .SCAN_DIV(2), .GAP_CYCLES(1)) u_dut5 (
      .clk(clk), .rst(rst5), .wr_valid(wv5), .wr_ready(wr5),
      .wr_idx(idx5), .wr_val(val5), .wr_on(on5), .wr_dp(dp5),
      .dec_b(decb5), .dec_h(dech5), .seg_n(seg5), .dig_n(dig5),
      .frame_tick(tick5)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: everything follows from the position p within the frame
   // ([gap,drive] per digit, then one commit cycle) and the two buffers.
   int         p = 0;
   bit         m_valid = 1'b0;
   logic [7:0] m_seg;
   logic [3:0] m_dig;
   logic [3:0] sh_val [N];
   logic [3:0] ac_val [N];
   bit         sh_on [N], ac_on [N], sh_dp [N], ac_dp [N];

   function automatic int ptr_at(input int pos);
      return (pos < N * SLOT) ? pos / SLOT : 0;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         p = 0; m_seg = 8'hFF; m_dig = 4'hF; m_valid = 1'b1;
         for (int i = 0; i < N; i++) begin
            sh_val[i] = 0; sh_on[i] = 0; sh_dp[i] = 0;
            ac_val[i] = 0; ac_on[i] = 0; ac_dp[i] = 0;
         end
      end else if (m_valid) begin
         logic [7:0] h;
         int d;
         d = p / SLOT;
         m_seg = 8'hFF; m_dig = 4'hF;
         if (p < N * SLOT && (p % SLOT) >= G) begin
            m_dig = ~(4'b0001 << d);
            h = ex7(ac_val[d]);
            if (ac_on[d]) m_seg = {h[7:1], ~ac_dp[d]};
         end
         if (wr_valid && p != P - 1) begin
            sh_val[wr_idx] = wr_val; sh_on[wr_idx] = wr_on; sh_dp[wr_idx] = wr_dp;
         end
         if (p == P - 1) begin
            for (int i = 0; i < N; i++) begin
               ac_val[i] = sh_val[i]; ac_on[i] = sh_on[i]; ac_dp[i] = sh_dp[i];
            end
         end
         p = (p + 1) % P;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("seg_n", seg_n, m_seg);
         chk("dig_n", dig_n, m_dig);
         chk("wr_ready", wr_ready, !rst && p != P - 1);
         chk("frame_tick", frame_tick, !rst && p == N * SLOT - 1);
         chk("dec_b", dec_b, ac_val[ptr_at(p)]);
      end
   end

   task automatic wait_tick(input string name);
      for (int i = 0; i < 2 * P; i++) begin
         @(negedge clk);
         if (frame_tick) return;
      end
      chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic wait_dig(input logic [3:0] v, input string name);
      for (int i = 0; i < 2 * P; i++) begin
         @(negedge clk);
         if (dig_n === v) return;
      end
      chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic wr(input logic [1:0] idx, input logic [3:0] v, input logic on, input logic dp);
      wr_valid = 1'b1; wr_idx = idx; wr_val = v; wr_on = on; wr_dp = dp;
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   initial begin
      int lows, first_low, tick_off, nonblank;

      // 1: reset hold, then first drive lights digit0
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t1_rst_seg", seg_n, 8'hFF);
      chk("t1_rst_dig", dig_n, 4'hF);
      chk("t1_rst_ready", wr_ready, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t1_ready_after", wr_ready, 1'b1);
      wait_dig(4'hE, "t1_first_drive");
      chk("t1_first_seg_blank", seg_n, 8'hFF);

      // 2: mid-frame write appears only after commit
      wr(2'd0, 4'h5, 1'b1, 1'b0);
      wait_tick("t2_tick");
      wait_dig(4'hE, "t2_drive");
      chk("t2_digit0_five", seg_n, 8'h49);

      // 3: dp lit on digit2 with value A
      wr(2'd2, 4'hA, 1'b1, 1'b1);
      wait_tick("t3_tick");
      wait_dig(4'hB, "t3_drive");
      chk("t3_digit2_a_dp", seg_n, 8'h10);

      // 4: continuous write request: single stall per frame, right after the tick
      wr_valid = 1'b1; wr_idx = 2'd1; wr_val = 4'h3; wr_on = 1'b1; wr_dp = 1'b0;
      wait_tick("t4_tick");
      lows = 0; first_low = -1; tick_off = -1;
      for (int i = 1; i <= P; i++) begin
         @(negedge clk);
         if (!wr_ready) begin
            lows++;
            if (first_low < 0) first_low = i;
         end
         if (frame_tick && tick_off < 0) tick_off = i;
      end
      wr_valid = 1'b0;
      chk("t4_stall_count", lows, 1);
      chk("t4_stall_offset", first_low, 1);
      chk("t4_frame_period", tick_off, 41);

      // 5: reset while driving digit2 clears everything
      wait_dig(4'hB, "t5_drive");
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5_dig_off", dig_n, 4'hF);
      chk("t5_seg_off", seg_n, 8'hFF);
      nonblank = 0;
      for (int i = 0; i < 2 * P; i++) begin
         @(negedge clk);
         if (seg_n !== 8'hFF) nonblank++;
      end
      chk("t5_all_blank", nonblank, 0);

      // 6: out-of-range index on a 5-digit instance is accepted and dropped
      @(posedge clk); #1;
      rst5 = 1'b0;
      wv5 = 1'b1; idx5 = 3'd5; val5 = 4'h8; on5 = 1'b1; dp5 = 1'b1;
      @(negedge clk);
      chk("t6_ready_idx5", wr5, 1'b1);
      @(posedge clk); #1;
      idx5 = 3'd7;
      @(negedge clk);
      chk("t6_ready_idx7", wr5, 1'b1);
      @(posedge clk); #1;
      wv5 = 1'b0;
      nonblank = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (seg5 !== 8'hFF) nonblank++;
      end
      chk("t6_dropped_blank", nonblank, 0);
      wv5 = 1'b1; idx5 = 3'd4; dp5 = 1'b0;
      @(posedge clk); #1;
      wv5 = 1'b0;
      nonblank = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (seg5 === 8'h01) nonblank++;
      end
      chk("t6_idx4_shown", nonblank > 0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
